// File: rtl/gpu_core_pkg.sv
// Shared types and default widths for the GPU core block sequencer.
// Holds the core FSM state encoding; no ports.
package gpu_core_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    DECODE  = 3'd2,
    REQUEST = 3'd3,
    WAIT    = 3'd4,
    EXECUTE = 3'd5,
    UPDATE  = 3'd6,
    DONE    = 3'd7
  } core_state_t;

  localparam int DEF_THREADS        = 4;
  localparam int DEF_PC_WIDTH       = 8;
  localparam int DEF_BLOCK_ID_WIDTH = 8;

endpackage

// File: rtl/core_block_sequencer_lane_select.sv
// Priority encoder: lowest enabled lane, and that lane's next PC.
// Ports: thread_enable_i, next_pc_i in; sel_pc_o out.
module lane_select
  import gpu_core_pkg::*;
#(
  parameter int THREADS  = DEF_THREADS,
  parameter int PC_WIDTH = DEF_PC_WIDTH
) (
  input  logic [THREADS-1:0]          thread_enable_i,
  input  logic [THREADS*PC_WIDTH-1:0] next_pc_i,
  output logic [PC_WIDTH-1:0]         sel_pc_o
);

  // Scan high to low so the lowest enabled lane wins.
  always_comb begin
    sel_pc_o = next_pc_i[PC_WIDTH-1:0];
    for (int i = THREADS - 1; i >= 0; i--) begin
      if (thread_enable_i[i]) begin
        sel_pc_o = next_pc_i[i*PC_WIDTH +: PC_WIDTH];
      end
    end
  end

endmodule

// File: rtl/core_block_sequencer.sv
// Core-side block sequencer: accepts a block, builds lane mask/base,
// runs the shared-PC fetch/decode/request/wait/execute/update loop.
// Ports: clk, reset (sync, active-high), start/block_id/thread_count
// dispatch inputs; done, thread_enable, thread_base, core_state, pc,
// fetch_req outputs; fetch_ack, decoded_ret, lsu_busy, next_pc inputs.
// Option: define DIVERGENCE_CHECK_EN to add the sticky diverged output.
module core_block_sequencer
  import gpu_core_pkg::*;
#(
  parameter int THREADS_PER_BLOCK = DEF_THREADS,
  parameter int PC_WIDTH          = DEF_PC_WIDTH,
  parameter int BLOCK_ID_WIDTH    = DEF_BLOCK_ID_WIDTH,
  localparam int CW = $clog2(THREADS_PER_BLOCK) + 1
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   start,
  input  logic [BLOCK_ID_WIDTH-1:0]              block_id,
  input  logic [CW-1:0]                          thread_count,
  output logic                                   done,
  output logic [THREADS_PER_BLOCK-1:0]           thread_enable,
  output logic [BLOCK_ID_WIDTH-1:0]              thread_base,
  output logic [2:0]                             core_state,
  output logic [PC_WIDTH-1:0]                    pc,
  output logic                                   fetch_req,
  input  logic                                   fetch_ack,
  input  logic                                   decoded_ret,
  input  logic [THREADS_PER_BLOCK-1:0]           lsu_busy,
  input  logic [THREADS_PER_BLOCK*PC_WIDTH-1:0]  next_pc
`ifdef DIVERGENCE_CHECK_EN
  ,
  output logic                                   diverged
`endif
);

  localparam int LOG_T = $clog2(THREADS_PER_BLOCK);

  core_state_t                   state_q;
  logic [PC_WIDTH-1:0]           pc_q;
  logic                          done_q;
  logic                          fetch_req_q;
  logic [THREADS_PER_BLOCK-1:0]  en_q;
  logic [BLOCK_ID_WIDTH-1:0]     base_q;

  logic [CW-1:0]                 cnt_d;
  logic [THREADS_PER_BLOCK-1:0]  en_d;
  logic [BLOCK_ID_WIDTH-1:0]     base_d;
  logic [PC_WIDTH-1:0]           sel_pc;

  // Clamp requested lanes to what the core has.
  assign cnt_d = (thread_count > CW'(THREADS_PER_BLOCK))
               ? CW'(THREADS_PER_BLOCK) : thread_count;

  always_comb begin
    en_d = '0;
    for (int i = 0; i < THREADS_PER_BLOCK; i++) begin
      en_d[i] = (CW'(i) < cnt_d);
    end
  end

  // Power-of-two lane count, so the multiply is a shift.
  assign base_d = block_id << LOG_T;

  lane_select #(
    .THREADS  (THREADS_PER_BLOCK),
    .PC_WIDTH (PC_WIDTH)
  ) u_sel (
    .thread_enable_i (en_q),
    .next_pc_i       (next_pc),
    .sel_pc_o        (sel_pc)
  );

`ifdef DIVERGENCE_CHECK_EN
  logic div_q;
  logic mismatch;

  always_comb begin
    mismatch = 1'b0;
    for (int i = 0; i < THREADS_PER_BLOCK; i++) begin
      if (en_q[i] && next_pc[i*PC_WIDTH +: PC_WIDTH] != sel_pc) begin
        mismatch = 1'b1;
      end
    end
  end

  assign diverged = div_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      pc_q        <= '0;
      done_q      <= 1'b0;
      fetch_req_q <= 1'b0;
      en_q        <= '0;
      base_q      <= '0;
`ifdef DIVERGENCE_CHECK_EN
      div_q       <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            en_q   <= en_d;
            base_q <= base_d;
            if (cnt_d == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q     <= FETCH;
              fetch_req_q <= 1'b1;
            end
          end
        end
        FETCH: begin
          if (fetch_ack) begin
            state_q     <= DECODE;
            fetch_req_q <= 1'b0;
          end
        end
        DECODE:  state_q <= REQUEST;
        REQUEST: state_q <= WAIT;
        WAIT: begin
          if ((lsu_busy & en_q) == '0) begin
            state_q <= EXECUTE;
          end
        end
        EXECUTE: state_q <= UPDATE;
        UPDATE: begin
          if (decoded_ret) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            pc_q        <= sel_pc;
            state_q     <= FETCH;
            fetch_req_q <= 1'b1;
`ifdef DIVERGENCE_CHECK_EN
            if (mismatch) begin
              div_q <= 1'b1;
            end
`endif
          end
        end
        DONE: state_q <= DONE;
      endcase
    end
  end

  assign done          = done_q;
  assign thread_enable = en_q;
  assign thread_base   = base_q;
  assign core_state    = state_q;
  assign pc            = pc_q;
  assign fetch_req     = fetch_req_q;

endmodule

// File: tb/tb_core_block_sequencer.sv
// Directed bench for core_block_sequencer.
// Hand-computed vectors; all checks go through chk().
module tb_core_block_sequencer;
  import gpu_core_pkg::*;

  localparam int T  = 4;
  localparam int PW = 8;
  localparam int BW = 8;
  localparam int CW = 3;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic [BW-1:0]   block_id;
  logic [CW-1:0]   thread_count;
  logic            done;
  logic [T-1:0]    thread_enable;
  logic [BW-1:0]   thread_base;
  logic [2:0]      core_state;
  logic [PW-1:0]   pc;
  logic            fetch_req;
  logic            fetch_ack;
  logic            decoded_ret;
  logic [T-1:0]    lsu_busy;
  logic [T*PW-1:0] next_pc;
`ifdef DIVERGENCE_CHECK_EN
  logic            diverged;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  core_block_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .block_id      (block_id),
    .thread_count  (thread_count),
    .done          (done),
    .thread_enable (thread_enable),
    .thread_base   (thread_base),
    .core_state    (core_state),
    .pc            (pc),
    .fetch_req     (fetch_req),
    .fetch_ack     (fetch_ack),
    .decoded_ret   (decoded_ret),
    .lsu_busy      (lsu_busy),
    .next_pc       (next_pc)
`ifdef DIVERGENCE_CHECK_EN
    ,
    .diverged      (diverged)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    start       = 1'b0;
    fetch_ack   = 1'b0;
    decoded_ret = 1'b0;
    lsu_busy    = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic dispatch(input int bid, input int tc);
    block_id     = BW'(bid);
    thread_count = CW'(tc);
    start        = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, "_state"}, 32'(core_state), 32'(IDLE));
    chk({tag, "_pc"}, 32'(pc), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_en"}, 32'(thread_enable), 0);
    chk({tag, "_base"}, 32'(thread_base), 0);
    chk({tag, "_freq"}, 32'(fetch_req), 0);
`ifdef DIVERGENCE_CHECK_EN
    chk({tag, "_div"}, 32'(diverged), 0);
`endif
  endtask

  // Counts WAIT cycles until EXECUTE; drops busy on WAIT cycle drop_at.
  task automatic measure_wait(input int drop_at, output int n);
    bit seen;
    n    = 0;
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (core_state == 3'(EXECUTE)) begin
        seen = 1'b1;
        break;
      end
      if (core_state == 3'(WAIT)) begin
        n++;
        if (n == drop_at) lsu_busy = '0;
      end
      tick();
    end
    if (!seen) chk("wait_timeout", 0, 1);
  endtask

  int n;
  bit seen;

  initial begin
    block_id     = '0;
    thread_count = '0;
    next_pc      = '0;
    do_reset();
    chk_rst("rst");

    // Full block, RET on first instruction.
    decoded_ret = 1'b1;
    fetch_ack   = 1'b1;
    dispatch(3, 4);
    chk("d_state", 32'(core_state), 32'(FETCH));
    chk("d_en", 32'(thread_enable), 32'hF);
    chk("d_base", 32'(thread_base), 12);
    chk("d_freq1", 32'(fetch_req), 1);
    tick();
    fetch_ack = 1'b0;
    chk("d_freq0", 32'(fetch_req), 0);
    tick();
    tick();
    tick();
    tick();
    chk("d_upd", 32'(core_state), 32'(UPDATE));
    chk("d_done0", 32'(done), 0);
    tick();
    chk("d_done6", 32'(done), 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("d_hold", 32'(core_state), 32'(DONE));
    chk("d_hold_done", 32'(done), 1);

    // Partial block, lowest lane selects pc.
    do_reset();
    next_pc = {8'd9, 8'd9, 8'd5, 8'd5};
    dispatch(0, 2);
    chk("p_en", 32'(thread_enable), 32'h3);
    fetch_ack = 1'b1;
    tick();
    fetch_ack = 1'b0;
    repeat (5) tick();
    chk("p_state", 32'(core_state), 32'(FETCH));
    chk("p_pc", 32'(pc), 5);
`ifdef DIVERGENCE_CHECK_EN
    chk("p_div", 32'(diverged), 0);
`endif

    // Memory wait on an enabled lane.
    fetch_ack = 1'b1;
    tick();
    fetch_ack = 1'b0;
    tick();
    lsu_busy = 4'b0010;
    tick();
    measure_wait(5, n);
    chk("m_wait5", 32'(n), 5);
    fetch_ack = 1'b1;
    tick();
    fetch_ack = 1'b0;
    chk("m_ack_exec", 32'(core_state), 32'(UPDATE));
    tick();
    chk("m_fetch", 32'(core_state), 32'(FETCH));

    // Fetch stall: ack on third FETCH cycle.
    n    = 0;
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (fetch_req) n++;
      if (n == 3) fetch_ack = 1'b1;
      tick();
      if (core_state == 3'(DECODE)) begin
        seen = 1'b1;
        break;
      end
    end
    fetch_ack = 1'b0;
    if (!seen) chk("f_timeout", 0, 1);
    chk("f_req3", 32'(n), 3);
    chk("f_req_low", 32'(fetch_req), 0);

    // Busy on a disabled lane is ignored.
    tick();
    lsu_busy = 4'b1000;
    tick();
    measure_wait(99, n);
    chk("m_wait1", 32'(n), 1);
    lsu_busy = '0;

    // Zero-thread block.
    do_reset();
    dispatch(5, 0);
    chk("z_state", 32'(core_state), 32'(DONE));
    chk("z_done", 32'(done), 1);
    chk("z_freq", 32'(fetch_req), 0);

    // Clamp and base truncation.
    do_reset();
    dispatch(70, 7);
    chk("c_en", 32'(thread_enable), 32'hF);
    chk("c_base", 32'(thread_base), 24);

    // Reset while waiting with RET pending.
    decoded_ret = 1'b1;
    fetch_ack   = 1'b1;
    tick();
    fetch_ack = 1'b0;
    tick();
    lsu_busy = 4'b1111;
    tick();
    chk("r_inwait", 32'(core_state), 32'(WAIT));
    reset = 1'b1;
    tick();
    reset    = 1'b0;
    lsu_busy = '0;
    chk_rst("rwait");
    tick();
    chk("r_idle", 32'(core_state), 32'(IDLE));
    dispatch(1, 3);
    chk("r_en", 32'(thread_enable), 32'h7);
    chk("r_base", 32'(thread_base), 4);
    chk("r_state", 32'(core_state), 32'(FETCH));
    chk("r_pc", 32'(pc), 0);

`ifdef DIVERGENCE_CHECK_EN
    do_reset();
    next_pc = {8'd0, 8'd0, 8'd6, 8'd5};
    dispatch(0, 2);
    fetch_ack = 1'b1;
    tick();
    fetch_ack = 1'b0;
    repeat (4) tick();
    chk("v_div0", 32'(diverged), 0);
    tick();
    chk("v_pc", 32'(pc), 5);
    chk("v_div1", 32'(diverged), 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/core_block_sequencer.md
Name: core_block_sequencer

Overview:
Core-side responder to the block dispatcher's start/done protocol.
- Accepts one block (block_id, thread_count) on start.
- Builds the active-thread mask and the global thread base for that block.
- Sequences the shared-PC instruction loop: fetch, decode, request, wait, execute, update.
- Raises done on RET. It is held in reset by the dispatcher between blocks.

Parameters:
- THREADS_PER_BLOCK, 4: threads (lanes) per core; power of two, 1..16.
- PC_WIDTH, 8: program counter width.
- BLOCK_ID_WIDTH, 8: width of block_id and thread_base.

Ports:
- clk  in  1  clock.
- reset  in  1  reset; synchronous, active-high. Driven by global reset OR the dispatcher's per-core reset.
- start  in  1  dispatcher start (level); sampled only in IDLE.
- block_id  in  BLOCK_ID_WIDTH  block index, valid while start=1.
- thread_count  in  $clog2(THREADS_PER_BLOCK)+1  active threads in this block.
- done  out  1  block complete; held until reset.
- thread_enable  out  THREADS_PER_BLOCK  active lane mask.
- thread_base  out  BLOCK_ID_WIDTH  block_id*THREADS_PER_BLOCK, truncated.
- core_state  out  3  current FSM state (package encoding).
- pc  out  PC_WIDTH  shared program counter.
- fetch_req  out  1  instruction fetch request.
- fetch_ack  in  1  fetcher has instruction ready.
- decoded_ret  in  1  decoder: current instruction is RET.
- lsu_busy  in  THREADS_PER_BLOCK  per-lane LSU outstanding.
- next_pc  in  THREADS_PER_BLOCK*PC_WIDTH  per-lane next PC; lane i at bits [i*PC_WIDTH +: PC_WIDTH].

Behaviour:
- Reset values:
  - state=IDLE, pc=0, done=0, thread_enable=0, thread_base=0, fetch_req=0.
  - Reset mid-block aborts immediately, with no residual state.
- IDLE: on start=1, latch block_id and thread_count.
  - Effective count = min(thread_count, THREADS_PER_BLOCK).
  - thread_enable[i] = (i < count).
  - thread_base = block_id*THREADS_PER_BLOCK, truncated.
  - Next state: FETCH, or DONE directly if count==0.
- FETCH: fetch_req=1, registered and asserted on FETCH entry.
  - On fetch_ack=1, go to DECODE; fetch_req=0 from that next cycle.
  - fetch_ack outside FETCH is ignored.
- DECODE: 1 cycle, then REQUEST.
- REQUEST: 1 cycle (LSUs sample the op), then WAIT.
- WAIT: minimum 1 cycle. Stay while (lsu_busy & thread_enable) != 0; otherwise go to EXECUTE.
  - Busy on disabled lanes is ignored.
- EXECUTE: 1 cycle, then UPDATE.
- UPDATE:
  - If decoded_ret=1: go to DONE; pc unchanged.
  - Else: pc <= next_pc of the lowest-index enabled lane; go to FETCH.
- DONE: done=1 held; start ignored; exits only via reset.
- start deasserting mid-block has no effect.
- Latency: a non-memory instruction with same-cycle ack takes 6 cycles, FETCH entry to next FETCH entry.
- pc wraps modulo 2^PC_WIDTH (value taken from next_pc).
- thread_enable and thread_base are stable from the cycle after start is accepted until reset.

Optional Feature:
- Macro: DIVERGENCE_CHECK_EN.
- Defined:
  - Adds output diverged (1 bit), reset 0.
  - Set sticky in UPDATE (non-RET) if any enabled lane's next_pc differs from the selected lane's.
  - Cleared only by reset; pc selection is unchanged.
- Undefined: no port, no compare logic.

Decomposition:
- Package gpu_core_pkg:
  - core_state_t enum, 3 bits: IDLE=0, FETCH=1, DECODE=2, REQUEST=3, WAIT=4, EXECUTE=5, UPDATE=6, DONE=7.
  - Default width constants.
- Sub-module lane_select: priority encoder from thread_enable to the lowest lane index, which muxes next_pc.

Test Plan:
- Dispatch: start=1, block_id=3, thread_count=4.
  - Expect thread_enable=4'b1111, thread_base=12, FETCH on the next cycle.
  - Then ack in 1 cycle, no busy, decoded_ret=1 → done=1 six cycles after FETCH entry.
- Partial block: thread_count=2, next_pc={lane3=9, lane2=9, lane1=5, lane0=5}, no RET.
  - Expect thread_enable=4'b0011, pc=5 after UPDATE.
- Memory wait: lsu_busy=4'b0010 for 5 cycles, then 0 → WAIT lasts 5 cycles.
  - With lsu_busy=4'b1000 and count=2 → WAIT lasts exactly 1 cycle.
- Fetch stall: fetch_ack delayed 3 cycles → fetch_req high 3 cycles, then low.
  - fetch_ack pulsed in EXECUTE → no effect.
- Boundaries:
  - thread_count=0 → DONE one cycle after start.
  - thread_count=7 → clamped, mask=4'b1111.
  - block_id=70 → thread_base=24 (280 mod 256).
- Reset in WAIT with done pending → all outputs return to reset values.
  - New start re-dispatches cleanly.
  - DIVERGENCE_CHECK_EN with lanes 5 vs 6 → diverged=1.
